// File: rtl/spy_pkg.sv
// Shared definitions for the spy trigger memory.
// Contents: FSM state type and encodings, default geometry constants.
package spy_pkg;

    localparam logic [1:0] STATE_RECORD_ENC = 2'd0;
    localparam logic [1:0] STATE_ARMED_ENC  = 2'd1;
    localparam logic [1:0] STATE_FROZEN_ENC = 2'd2;

    typedef enum logic [1:0] {
        RECORD = STATE_RECORD_ENC,
        ARMED  = STATE_ARMED_ENC,
        FROZEN = STATE_FROZEN_ENC
    } spy_state_t;

    localparam int DEFAULT_WIDTH     = 6;
    localparam int DEFAULT_DATAWIDTH = 64;

endpackage

// File: rtl/spy_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-first.
// The array carries no reset so it maps onto block RAM; only the read
// output register is reset.
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   write_enable/addr/data       write port
//   read_enable/addr             read request
//   read_data                    registered read result, holds when idle
module spy_sdp_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_enable,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [DATA_W-1:0] read_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[write_addr] <= write_data;
        end
    end

    // Non-blocking read of the same array gives old contents on a
    // same-address collision (read-first).
    always_ff @(posedge clock) begin
        if (reset) begin
            read_data <= '0;
        end else if (read_enable) begin
            read_data <= mem[read_addr];
        end
    end

endmodule

// File: rtl/spy_trigger_memory.sv
// Ring-buffer spy memory with trigger-and-freeze capture.
// Records words continuously; after a trigger, post_count further words are
// stored and the buffer then freezes for readout until unfreeze.
// Optional build macro: SPY_TRIGGER_MEMORY_PARITY_EN adds an even-parity bit
// per stored word and a parity_error output alongside read_data.
// Ports:
//   clock, reset          clock, synchronous active-high reset
//   write_enable/data     record a word (dropped while frozen)
//   trigger, post_count   start post-trigger countdown (RECORD only)
//   unfreeze              leave FROZEN
//   read_enable/addr      read request, result one cycle later
//   read_data/read_valid  registered read result and its strobe
//   write_pointer         next write address
//   occupancy             stored words, saturating at 2**WIDTH
//   looped, dropped       sticky wrap / dropped-write flags
//   frozen, trigger_addr  freeze status and write pointer at trigger
//
// state  | meaning
// RECORD | free-running capture, trigger accepted
// ARMED  | counting down post-trigger writes
// FROZEN | writes dropped, contents held for readout
module spy_trigger_memory
    import spy_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 write_enable,
    input  logic [DATAWIDTH-1:0] write_data,
    input  logic                 trigger,
    input  logic [WIDTH-1:0]     post_count,
    input  logic                 unfreeze,
    input  logic                 read_enable,
    input  logic [WIDTH-1:0]     read_addr,
    output logic [DATAWIDTH-1:0] read_data,
    output logic                 read_valid,
    output logic [WIDTH-1:0]     write_pointer,
    output logic [WIDTH:0]       occupancy,
`ifdef SPY_TRIGGER_MEMORY_PARITY_EN
    output logic                 parity_error,
`endif
    output logic                 looped,
    output logic                 frozen,
    output logic [WIDTH-1:0]     trigger_addr,
    output logic                 dropped
);

`ifdef SPY_TRIGGER_MEMORY_PARITY_EN
    localparam int MEM_W = DATAWIDTH + 1;
`else
    localparam int MEM_W = DATAWIDTH;
`endif

    localparam logic [WIDTH:0]   OCC_FULL  = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH-1:0] LAST_ADDR = '1;

    spy_state_t       state, state_next;
    logic [WIDTH-1:0] wptr;
    logic [WIDTH-1:0] remaining, remaining_next;
    logic             trig_take;
    logic             store;
    logic             rem_dec;
    logic [MEM_W-1:0] ram_wdata;
    logic [MEM_W-1:0] ram_rdata;

    assign store   = write_enable && (state != FROZEN);
    assign rem_dec = store && (remaining != '0);

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        trig_take      = 1'b0;
        case (state)
            RECORD: begin
                if (trigger) begin
                    state_next     = ARMED;
                    remaining_next = post_count;
                    trig_take      = 1'b1;
                end
            end
            ARMED: begin
                if (rem_dec) begin
                    remaining_next = remaining - 1'b1;
                end
                // Terminal count: freeze once the countdown reaches zero,
                // including the post_count == 0 case.
                if (remaining_next == '0) begin
                    state_next = FROZEN;
                end
            end
            FROZEN: begin
                if (unfreeze) begin
                    state_next = RECORD;
                end
            end
            default: state_next = RECORD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RECORD;
            remaining    <= '0;
            wptr         <= '0;
            occupancy    <= '0;
            trigger_addr <= '0;
            looped       <= 1'b0;
            dropped      <= 1'b0;
            read_valid   <= 1'b0;
        end else begin
            state      <= state_next;
            remaining  <= remaining_next;
            read_valid <= read_enable;
            if (trig_take) begin
                trigger_addr <= wptr;
            end
            if (store) begin
                wptr <= wptr + 1'b1;
                if (occupancy != OCC_FULL) begin
                    occupancy <= occupancy + 1'b1;
                end
                if (wptr == LAST_ADDR) begin
                    looped <= 1'b1;
                end
            end
            if (write_enable && (state == FROZEN)) begin
                dropped <= 1'b1;
            end
        end
    end

`ifdef SPY_TRIGGER_MEMORY_PARITY_EN
    // Even parity: the stored word including its parity bit has an even
    // number of ones, so any odd-bit corruption reads back as odd.
    assign ram_wdata    = {^write_data, write_data};
    assign parity_error = ^ram_rdata;
`else
    assign ram_wdata = write_data;
`endif

    spy_sdp_ram #(
        .ADDR_W (WIDTH),
        .DATA_W (MEM_W)
    ) u_ram (
        .clock        (clock),
        .reset        (reset),
        .write_enable (store && !reset),
        .write_addr   (wptr),
        .write_data   (ram_wdata),
        .read_enable  (read_enable),
        .read_addr    (read_addr),
        .read_data    (ram_rdata)
    );

    assign read_data     = ram_rdata[DATAWIDTH-1:0];
    assign write_pointer = wptr;
    assign frozen        = (state == FROZEN);

endmodule

// File: tb/tb_spy_trigger_memory.sv
module tb_spy_trigger_memory;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int ncmp  = 0;
    int nfail = 0;

    // default-geometry instance (WIDTH 6, DATAWIDTH 64)
    logic        we = 0, trig = 0, unf = 0, re = 0;
    logic [63:0] wd = '0;
    logic [5:0]  pc = '0, ra = '0;
    logic [63:0] rd;
    logic        rv, lp, fz, dr;
    logic [5:0]  wp, ta;
    logic [6:0]  occ;

    // small instance (WIDTH 3, DATAWIDTH 8) for wrap tests
    logic        s_we = 0, s_trig = 0, s_unf = 0, s_re = 0;
    logic [7:0]  s_wd = '0;
    logic [2:0]  s_pc = '0, s_ra = '0;
    logic [7:0]  s_rd;
    logic        s_rv, s_lp, s_fz, s_dr;
    logic [2:0]  s_wp, s_ta;
    logic [3:0]  s_occ;

`ifdef SPY_TRIGGER_MEMORY_PARITY_EN
    logic pe, s_pe;
`endif

    spy_trigger_memory dut (
        .clock(clock), .reset(reset),
        .write_enable(we), .write_data(wd),
        .trigger(trig), .post_count(pc), .unfreeze(unf),
        .read_enable(re), .read_addr(ra),
        .read_data(rd), .read_valid(rv),
        .write_pointer(wp), .occupancy(occ),
`ifdef SPY_TRIGGER_MEMORY_PARITY_EN
        .parity_error(pe),
`endif
        .looped(lp), .frozen(fz), .trigger_addr(ta), .dropped(dr)
    );

    spy_trigger_memory #(.WIDTH(3), .DATAWIDTH(8)) dut3 (
        .clock(clock), .reset(reset),
        .write_enable(s_we), .write_data(s_wd),
        .trigger(s_trig), .post_count(s_pc), .unfreeze(s_unf),
        .read_enable(s_re), .read_addr(s_ra),
        .read_data(s_rd), .read_valid(s_rv),
        .write_pointer(s_wp), .occupancy(s_occ),
`ifdef SPY_TRIGGER_MEMORY_PARITY_EN
        .parity_error(s_pe),
`endif
        .looped(s_lp), .frozen(s_fz), .trigger_addr(s_ta), .dropped(s_dr)
    );

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        @(negedge clock);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("rst_occ", 64'(occ), 64'd0);
        check("rst_wptr", 64'(wp), 64'd0);
        check("rst_looped", 64'(lp), 64'd0);
        check("rst_frozen", 64'(fz), 64'd0);
        check("rst_dropped", 64'(dr), 64'd0);
        check("rst_rvalid", 64'(rv), 64'd0);
        check("rst_rdata", rd, 64'd0);
        check("rst_taddr", 64'(ta), 64'd0);

        // ---- WIDTH=3: wrap and saturation ----
        for (int i = 0; i < 7; i++) begin
            s_we = 1'b1; s_wd = 8'(i);
            tick();
        end
        check("s_looped_before_wrap", 64'(s_lp), 64'd0);
        s_wd = 8'd7; tick();
        check("s_looped_at_wrap", 64'(s_lp), 64'd1);
        check("s_wptr_at_wrap", 64'(s_wp), 64'd0);
        check("s_occ_full", 64'(s_occ), 64'd8);
        s_wd = 8'd8; tick();
        s_we = 1'b0;
        check("s_wptr_9", 64'(s_wp), 64'd1);
        check("s_occ_sat", 64'(s_occ), 64'd8);
        check("s_looped_sticky", 64'(s_lp), 64'd1);
        s_re = 1'b1; s_ra = 3'd0; tick();
        check("s_rd_addr0", 64'(s_rd), 64'd8);
        check("s_rvalid", 64'(s_rv), 64'd1);
        // same-cycle write and read of addr 1: old contents (1) returned
        s_we = 1'b1; s_wd = 8'h55; s_ra = 3'd1; tick();
        s_we = 1'b0;
        check("s_read_first", 64'(s_rd), 64'd1);
        tick();
        s_re = 1'b0;
        check("s_reread", 64'(s_rd), 64'h55);
        tick();
        check("s_rvalid_drop", 64'(s_rv), 64'd0);
        check("s_rdata_hold", 64'(s_rd), 64'h55);

        // ---- default geometry: basic write / readback ----
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; wd = 64'h10 + 64'(i);
            tick();
        end
        we = 1'b0;
        check("occ_4", 64'(occ), 64'd4);
        check("wptr_4", 64'(wp), 64'd4);
        check("looped_0", 64'(lp), 64'd0);
        for (int i = 0; i < 4; i++) begin
            re = 1'b1; ra = 6'(i);
            tick();
            check("rd_seq", rd, 64'h10 + 64'(i));
            check("rv_seq", 64'(rv), 64'd1);
        end
        re = 1'b0; tick();
        check("rv_low", 64'(rv), 64'd0);
        check("rd_hold", rd, 64'h13);
`ifdef SPY_TRIGGER_MEMORY_PARITY_EN
        check("parity_ok", 64'(pe), 64'd0);
`endif

        // ---- trigger with post_count = 2 at wptr 5 ----
        we = 1'b1; wd = 64'h14; tick();
        trig = 1'b1; pc = 6'd2; wd = 64'hAA; tick();
        check("taddr_5", 64'(ta), 64'd5);
        check("armed_not_frozen", 64'(fz), 64'd0);
        pc = 6'd7; wd = 64'hBB; tick();          // trigger ignored while ARMED
        trig = 1'b0;
        check("taddr_keep", 64'(ta), 64'd5);
        check("frozen_after_bb", 64'(fz), 64'd0);
        wd = 64'hCC; tick();
        check("frozen_after_cc", 64'(fz), 64'd1);
        check("wptr_8", 64'(wp), 64'd8);
        check("dropped_not_yet", 64'(dr), 64'd0);
        wd = 64'hDD; tick();
        we = 1'b0;
        check("dropped_set", 64'(dr), 64'd1);
        check("wptr_hold", 64'(wp), 64'd8);
        check("occ_8", 64'(occ), 64'd8);
        re = 1'b1; ra = 6'd7; tick();
        check("rd_cc", rd, 64'hCC);
        ra = 6'd5; tick();
        re = 1'b0;
        check("rd_aa", rd, 64'hAA);
        check("frozen_during_read", 64'(fz), 64'd1);

        // ---- trigger + unfreeze together while FROZEN, write in same cycle ----
        trig = 1'b1; unf = 1'b1; pc = 6'd3; we = 1'b1; wd = 64'h66; tick();
        trig = 1'b0; unf = 1'b0;
        check("unfrozen", 64'(fz), 64'd0);
        check("wptr_unfreeze_drop", 64'(wp), 64'd8);
        check("taddr_unchanged", 64'(ta), 64'd5);
        for (int i = 0; i < 4; i++) begin
            wd = 64'h77 + 64'(i); tick();
        end
        we = 1'b0;
        check("record_not_armed", 64'(fz), 64'd0);
        check("wptr_12", 64'(wp), 64'd12);
        check("occ_12", 64'(occ), 64'd12);
        re = 1'b1; ra = 6'd8; tick();
        re = 1'b0;
        check("rd_held_wptr", rd, 64'h77);

        // ---- post_count = 0 ----
        trig = 1'b1; pc = 6'd0; we = 1'b1; wd = 64'h90; tick();
        trig = 1'b0;
        check("pc0_armed", 64'(fz), 64'd0);
        check("pc0_taddr", 64'(ta), 64'd12);
        wd = 64'h91; tick();
        check("pc0_frozen", 64'(fz), 64'd1);
        check("pc0_wptr", 64'(wp), 64'd14);
        wd = 64'h92; tick();
        we = 1'b0;
        check("pc0_drop_wptr", 64'(wp), 64'd14);
        re = 1'b1; ra = 6'd13; tick();
        re = 1'b0;
        check("pc0_rd", rd, 64'h91);

        // ---- reset while ARMED ----
        unf = 1'b1; tick();
        unf = 1'b0;
        check("pc0_unfrozen", 64'(fz), 64'd0);
        trig = 1'b1; pc = 6'd5; tick();
        trig = 1'b0;
        reset = 1'b1; re = 1'b1; ra = 6'd0; tick();
        reset = 1'b0; re = 1'b0;
        check("rst2_frozen", 64'(fz), 64'd0);
        check("rst2_occ", 64'(occ), 64'd0);
        check("rst2_wptr", 64'(wp), 64'd0);
        check("rst2_looped", 64'(lp), 64'd0);
        check("rst2_rvalid", 64'(rv), 64'd0);
        check("rst2_dropped", 64'(dr), 64'd0);
        check("rst2_taddr", 64'(ta), 64'd0);
        check("rst2_rdata", rd, 64'd0);
        check("s_rst2_looped", 64'(s_lp), 64'd0);
        we = 1'b1; wd = 64'hE0; tick();
        we = 1'b0;
        check("post_rst_wptr", 64'(wp), 64'd1);
        check("post_rst_occ", 64'(occ), 64'd1);
        tick();
        check("post_rst_not_frozen", 64'(fz), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/spy_trigger_memory.md
# spy_trigger_memory

Parametrised successor to the spy-buffer circular memory. It continuously records words into a ring buffer and tracks occupancy and wrap status. It supports trigger-and-freeze capture: after a trigger, a programmable number of post-trigger words is recorded and the buffer then freezes for readout. It sits between the spy-buffer input FIFO and the readout/IPbus side, and maps onto a simple dual-port block RAM.

## Interface
Parameters:
- WIDTH, 6, address width; depth SIZE = 2**WIDTH
- DATAWIDTH, 64, stored word width

Ports:
- clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- write_enable  in  1  store write_data this cycle (ignored when FROZEN)
- write_data  in  DATAWIDTH  word to record
- trigger  in  1  start post-trigger countdown (honoured only in RECORD)
- post_count  in  WIDTH  post-trigger words to record; sampled when trigger is honoured
- unfreeze  in  1  return from FROZEN to RECORD
- read_enable  in  1  read request
- read_addr  in  WIDTH  address to read
- read_data  out  DATAWIDTH  registered read result
- read_valid  out  1  read_data updated this cycle
- write_pointer  out  WIDTH  next write address
- occupancy  out  WIDTH+1  valid words, saturating at SIZE
- looped  out  1  sticky: write pointer has wrapped at least once
- frozen  out  1  state == FROZEN
- trigger_addr  out  WIDTH  write_pointer sampled when trigger was honoured
- dropped  out  1  sticky: write_enable seen while FROZEN

## Operation
- States: RECORD (2'd0), ARMED (2'd1), FROZEN (2'd2).
- RECORD:
  - write_enable stores at wptr; wptr increments modulo SIZE.
  - trigger moves to ARMED and latches trigger_addr = wptr and remaining = post_count.
  - A write in the trigger cycle is the trigger word and does not decrement remaining.
- ARMED:
  - Each write stores and decrements remaining.
  - When remaining == 0 and the FSM is in ARMED, the next state is FROZEN.
  - post_count = 0 therefore freezes one cycle after the trigger, with the trigger word stored.
  - A write in the ARMED cycle where remaining == 0 is still stored.
- FROZEN:
  - Writes are dropped and wptr is held.
  - A write attempt sets dropped.
  - unfreeze returns to RECORD; occupancy, looped and memory are kept.
- Precedence rules:
  - trigger in ARMED or FROZEN is ignored.
  - trigger and unfreeze together in FROZEN: unfreeze wins, trigger ignored.
  - unfreeze outside FROZEN is ignored.
- occupancy increments on each stored write and holds at SIZE.
- looped sets when a stored write moves wptr from SIZE-1 to 0.
- dropped clears only on reset.
- Reads are allowed in every state and do not disturb the FSM.
- Read of the address being written in the same cycle returns the old contents (read-first).
- Reset values:
  - state RECORD.
  - wptr, occupancy, trigger_addr and remaining are 0.
  - looped, dropped, frozen, read_valid and read_data are 0.
  - Memory contents are not cleared.
- Reset mid-ARMED or mid-FROZEN aborts to RECORD immediately.

## Timing
- Write latency: data accepted at cycle N is readable by a read issued at N+1.
- Read latency: 1 cycle. read_enable at N gives read_data and read_valid at N+1. read_valid is high for exactly one cycle per request.
- read_data holds its last value when read_enable is low.
- write_pointer and occupancy reflect writes accepted up to the previous edge.
- frozen asserts the cycle after the last post-trigger write, or one cycle after the trigger when post_count = 0.
- unfreeze at N: writes at N are dropped; writes at N+1 are stored.

## Configuration
- SPY_TRIGGER_MEMORY_PARITY_EN defined:
  - Memory word widens to DATAWIDTH+1 with an even-parity bit computed on write.
  - Read adds output parity_error (1 bit), valid with read_valid and reset to 0.
- Undefined: memory is DATAWIDTH wide and the parity_error port is absent.

## Structure
- Shared package spy_pkg:
  - spy_state_t enum (RECORD/ARMED/FROZEN, 2 bits)
  - state encoding localparams
  - default WIDTH and DATAWIDTH constants
- Sub-module spy_sdp_ram:
  - Simple dual-port RAM: one write port, one registered read port, read-first.
  - No reset on the array, so it infers block RAM.
- Top level holds the FSM, counters and flags.

## Test plan
- Reset, then write 0x10..0x13 at addresses 0..3, then read addresses 0..3 back-to-back → read_data 0x10..0x13, each one cycle after its request; occupancy = 4, looped = 0.
- WIDTH = 3: write 9 words 0..8 → write_pointer = 1, looped = 1, occupancy = 8 (saturated), addr 0 reads 8.
- Trigger with post_count = 2 at wptr = 5 while writing 0xAA, then write 0xBB, 0xCC, 0xDD → trigger_addr = 5, frozen after 0xCC; 0xDD dropped, dropped = 1, write_pointer = 8.
- While FROZEN, assert trigger and unfreeze together → state RECORD, next write stored at the held wptr, trigger_addr unchanged.
- Write 0x55 and read the same address in the same cycle → old contents returned; a re-read the next cycle returns 0x55.
- Assert reset while ARMED → next cycle frozen = 0, occupancy = 0, write_pointer = 0, looped = 0, read_valid = 0.
